// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states and byte masks.
// Optional build macro used by the LSU: LSU_MISALIGN_FAULT_EN.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H    = 4'b0011;
    localparam logic [3:0] MASK_W    = 4'b1111;

    // Stores only exist as B/H/W; loads add the unsigned B/H variants.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication / byte mask, and load lane extract with extension.
// Unused low address bits are ignored, so misaligned H/W accesses fold onto the aligned lane.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_st_funct3,
    input  logic [1:0]      i_st_addr_lo,
    input  logic [XLEN-1:0] i_st_data,
    output logic [XLEN-1:0] o_st_wdata,
    output logic [3:0]      o_st_mask,
    input  logic [2:0]      i_ld_funct3,
    input  logic [1:0]      i_ld_addr_lo,
    input  logic [XLEN-1:0] i_ld_word,
    output logic [XLEN-1:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every output of a combinational block gets a default before the case, so no path can infer a latch.
    always_comb begin
        o_st_wdata = i_st_data;
        o_st_mask  = MASK_W;
        case (i_st_funct3)
            F3_B: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_mask  = MASK_B << i_st_addr_lo;
            end
            F3_H: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_mask  = MASK_H << {i_st_addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_byte = i_ld_word[{i_ld_addr_lo, 3'b000} +: 8];
    assign w_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];

    always_comb begin
        o_ld_data = i_ld_word;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_ld_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {{(XLEN-16){1'b0}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator driving a single-cycle synchronous memory; one request in flight.
// Optional macro LSU_MISALIGN_FAULT_EN: misaligned H/HU/SH/W/SW fault instead of being force-aligned.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_ren,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_mask
);

    localparam logic [XLEN-3:0] WORD_LIMIT = (XLEN-2)'(MEM_WORDS);

    lsu_state_e      r_state, w_state_nxt;
    logic            r_we, w_we_nxt;
    logic [2:0]      r_funct3, w_funct3_nxt;
    logic [1:0]      r_addr_lo, w_addr_lo_nxt;
    logic [XLEN-1:0] r_mem_addr, w_mem_addr_nxt;
    logic            r_mem_ren, w_mem_ren_nxt;
    logic            r_mem_wen, w_mem_wen_nxt;
    logic [XLEN-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]      r_mem_mask, w_mem_mask_nxt;
    logic            r_resp_valid, w_resp_valid_nxt;
    logic            r_resp_fault, w_resp_fault_nxt;
    logic [XLEN-1:0] r_resp_rdata, w_resp_rdata_nxt;

    logic            w_accept;
    logic            w_out_of_range;
    logic            w_misalign;
    logic            w_fault;
    logic [XLEN-1:0] w_st_wdata;
    logic [3:0]      w_st_mask;
    logic [XLEN-1:0] w_ld_data;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_st_funct3  (req_funct3),
        .i_st_addr_lo (req_addr[1:0]),
        .i_st_data    (req_wdata),
        .o_st_wdata   (w_st_wdata),
        .o_st_mask    (w_st_mask),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_word    (mem_rdata),
        .o_ld_data    (w_ld_data)
    );

    assign req_ready      = (r_state == ST_IDLE) && !rst;
    assign w_accept       = req_valid && req_ready;
    assign w_out_of_range = req_addr[XLEN-1:2] >= WORD_LIMIT;

`ifdef LSU_MISALIGN_FAULT_EN
    assign w_misalign = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                        ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = !funct3_legal(req_we, req_funct3) || w_out_of_range || w_misalign;

    always_comb begin
        w_state_nxt      = r_state;
        w_we_nxt         = r_we;
        w_funct3_nxt     = r_funct3;
        w_addr_lo_nxt    = r_addr_lo;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_ren_nxt    = 1'b0;
        w_mem_wen_nxt    = 1'b0;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_mask_nxt   = MASK_NONE;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_fault_nxt = r_resp_fault;
        w_resp_rdata_nxt = r_resp_rdata;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_we_nxt         = req_we;
                    w_funct3_nxt     = req_funct3;
                    w_addr_lo_nxt    = req_addr[1:0];
                    w_resp_rdata_nxt = '0;
                    if (w_fault) begin
                        w_state_nxt      = ST_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt      = ST_ACCESS;
                        w_resp_fault_nxt = 1'b0;
                        w_mem_addr_nxt   = {req_addr[XLEN-1:2], 2'b00};
                        if (req_we) begin
                            w_mem_wen_nxt   = 1'b1;
                            w_mem_wdata_nxt = w_st_wdata;
                            w_mem_mask_nxt  = w_st_mask;
                        end else begin
                            w_mem_ren_nxt   = 1'b1;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (r_we) begin
                    w_state_nxt      = ST_RESP;
                    w_resp_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt      = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                w_state_nxt      = ST_RESP;
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = w_ld_data;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt      = ST_IDLE;
                    w_resp_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block; sequential state uses <= only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_mem_addr   <= '0;
            r_mem_ren    <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_wdata  <= '0;
            r_mem_mask   <= MASK_NONE;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_we         <= w_we_nxt;
            r_funct3     <= w_funct3_nxt;
            r_addr_lo    <= w_addr_lo_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_ren    <= w_mem_ren_nxt;
            r_mem_wen    <= w_mem_wen_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_mask   <= w_mem_mask_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_fault <= w_resp_fault_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_ren    = r_mem_ren;
    assign mem_wen    = r_mem_wen;
    assign mem_wdata  = r_mem_wdata;
    assign mem_mask   = r_mem_mask;
    assign resp_valid = r_resp_valid;
    assign resp_fault = r_resp_fault;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-masked synchronous memory model.
// Honours LSU_MISALIGN_FAULT_EN for the misaligned-load step.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_rdata, mem_wdata;
    logic        mem_ren, mem_wen;
    logic [3:0]  mem_mask;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:1023];

    lsu_mem_master #(.XLEN(32), .MEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_addr   (mem_addr),
        .mem_ren    (mem_ren),
        .mem_rdata  (mem_rdata),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask)
    );

    always #5 clk = ~clk;

    // Single-cycle synchronous memory: masked write, registered read.
    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_ren) mem_rdata <= mem[mem_addr[11:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        check({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, " resp_valid drop"}, {31'b0, resp_valid}, 32'd0);
        check({tag, " req_ready back"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] exp_mask, input logic [31:0] exp_wdata, input string tag);
        issue(1'b1, f3, addr, wdata, tag);
        check({tag, " T1 wen"}, {31'b0, mem_wen}, 32'd1);
        check({tag, " T1 ren"}, {31'b0, mem_ren}, 32'd0);
        check({tag, " T1 addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, " T1 mask"}, {28'b0, mem_mask}, {28'b0, exp_mask});
        check({tag, " T1 wdata"}, mem_wdata, exp_wdata);
        check({tag, " T1 resp_valid"}, {31'b0, resp_valid}, 32'd0);
        step();
        check({tag, " T2 resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, " T2 fault"}, {31'b0, resp_fault}, 32'd0);
        check({tag, " T2 rdata"}, resp_rdata, 32'd0);
        check({tag, " T2 wen"}, {31'b0, mem_wen}, 32'd0);
        handshake(tag);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp_maddr,
                           input logic [31:0] exp_rdata, input string tag);
        issue(1'b0, f3, addr, 32'h0, tag);
        check({tag, " T1 ren"}, {31'b0, mem_ren}, 32'd1);
        check({tag, " T1 wen"}, {31'b0, mem_wen}, 32'd0);
        check({tag, " T1 addr"}, mem_addr, exp_maddr);
        step();
        check({tag, " T2 resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, " T2 ren"}, {31'b0, mem_ren}, 32'd0);
        step();
        check({tag, " T3 resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, " T3 fault"}, {31'b0, resp_fault}, 32'd0);
        check({tag, " T3 rdata"}, resp_rdata, exp_rdata);
        handshake(tag);
    endtask

    task automatic do_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr, input string tag);
        issue(we, f3, addr, 32'hFFFF_FFFF, tag);
        check({tag, " T1 resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, " T1 fault"}, {31'b0, resp_fault}, 32'd1);
        check({tag, " T1 rdata"}, resp_rdata, 32'd0);
        check({tag, " T1 ren"}, {31'b0, mem_ren}, 32'd0);
        check({tag, " T1 wen"}, {31'b0, mem_wen}, 32'd0);
        handshake(tag);
        check({tag, " no ren after"}, {31'b0, mem_ren}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem_rdata  = 32'h0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        step();
        step();
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp_fault", {31'b0, resp_fault}, 32'd0);
        check("rst mem_ren", {31'b0, mem_ren}, 32'd0);
        check("rst mem_wen", {31'b0, mem_wen}, 32'd0);
        check("rst mem_mask", {28'b0, mem_mask}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle req_ready", {31'b0, req_ready}, 32'd1);

        do_store(F3_W, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "SW 0x10");
        do_load(F3_W, 32'h10, 32'h10, 32'hDEAD_BEEF, "LW 0x10");

`ifdef LSU_MISALIGN_FAULT_EN
        do_fault(1'b0, F3_W, 32'h11, "LW 0x11 misalign");
        do_fault(1'b0, F3_H, 32'h11, "LH 0x11 misalign");
`else
        do_load(F3_W, 32'h11, 32'h10, 32'hDEAD_BEEF, "LW 0x11 folded");
        do_load(F3_H, 32'h11, 32'h10, 32'hFFFF_BEEF, "LH 0x11 folded");
`endif

        // Word 0x10 becomes 0xA5ADBEEF after the byte store.
        do_store(F3_B, 32'h13, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, "SB 0x13");
        do_load(F3_B, 32'h13, 32'h10, 32'hFFFF_FFA5, "LB 0x13");
        do_load(F3_BU, 32'h13, 32'h10, 32'h0000_00A5, "LBU 0x13");
        do_load(F3_B, 32'h10, 32'h10, 32'hFFFF_FFEF, "LB 0x10");
        do_load(F3_HU, 32'h12, 32'h10, 32'h0000_A5AD, "LHU 0x12");
        do_load(F3_H, 32'h10, 32'h10, 32'hFFFF_BEEF, "LH 0x10");

        do_store(F3_H, 32'h22, 32'h0000_8001, 4'b1100, 32'h8001_8001, "SH 0x22");
        do_load(F3_H, 32'h22, 32'h20, 32'hFFFF_8001, "LH 0x22");
        do_load(F3_HU, 32'h22, 32'h20, 32'h0000_8001, "LHU 0x22");
        do_load(F3_W, 32'h20, 32'h20, 32'h8001_0000, "LW 0x20");

        do_store(F3_W, 32'hFFC, 32'h1234_5678, 4'b1111, 32'h1234_5678, "SW 0xFFC");
        do_load(F3_W, 32'hFFC, 32'hFFC, 32'h1234_5678, "LW 0xFFC");
        do_fault(1'b0, F3_W, 32'h1000, "LW 0x1000 range");
        do_fault(1'b1, F3_W, 32'h8000_0000, "SW high range");
        do_fault(1'b1, 3'b100, 32'h10, "store f3=100");
        do_fault(1'b0, 3'b011, 32'h10, "load f3=011");
        do_fault(1'b0, 3'b111, 32'h10, "load f3=111");

        // Backpressure: response held stable, no new request accepted.
        issue(1'b0, F3_W, 32'h10, 32'h0, "LW hold");
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            check("hold resp_valid", {31'b0, resp_valid}, 32'd1);
            check("hold rdata", resp_rdata, 32'hA5AD_BEEF);
            check("hold req_ready", {31'b0, req_ready}, 32'd0);
            check("hold ren", {31'b0, mem_ren}, 32'd0);
            step();
        end
        req_valid = 1'b0;
        handshake("LW hold");

        // Reset during RDWAIT discards the outstanding response.
        issue(1'b0, F3_W, 32'h20, 32'h0, "LW rst");
        step();
        rst = 1'b1;
        check("rst mid req_ready", {31'b0, req_ready}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("rst mid resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst mid req_ready idle", {31'b0, req_ready}, 32'd1);
        step();
        step();
        check("rst mid no late resp", {31'b0, resp_valid}, 32'd0);

        // A request after reset recovery completes normally.
        do_load(F3_W, 32'h20, 32'h20, 32'h8001_0000, "LW after rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
